// File: rtl/clk_div_bank.sv
// Bank of NCH independent programmable clock dividers with shadowed
// half-period reload, per-channel enable and a global phase-align strobe.
module clk_div_bank #(
    parameter int NCH      = 4,
    parameter int CW       = 24,
    parameter int DEF_HALF = 200000,
    localparam int LCW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] en,
    input  logic           load,
    input  logic [LCW-1:0] load_ch,
    input  logic [CW-1:0]  load_val,
    input  logic           sync,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick
);

    localparam logic [CW-1:0] DEF_HALF_C = CW'(DEF_HALF);

    logic [CW-1:0]  cnt_q  [NCH];
    logic [CW-1:0]  cnt_d  [NCH];
    logic [CW-1:0]  half_q [NCH];
    logic [CW-1:0]  half_d [NCH];
    logic [CW-1:0]  pval_q [NCH];
    logic [CW-1:0]  pval_d [NCH];
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] pend_d;
    logic [NCH-1:0] clk_q;
    logic [NCH-1:0] clk_d;
    logic [NCH-1:0] tick_q;
    logic [NCH-1:0] tick_d;
    logic [NCH-1:0] hit;

    // An out-of-range load_ch matches no channel, so such a load is dropped.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            hit[i] = load && (load_ch == LCW'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]  = cnt_q[i];
            half_d[i] = half_q[i];
            pval_d[i] = pval_q[i];
            pend_d[i] = pend_q[i];
            clk_d[i]  = clk_q[i];
            tick_d[i] = tick_q[i];

            if (sync) begin
                // Older pending value goes live; a load arriving now stays shadowed.
                cnt_d[i]  = '0;
                clk_d[i]  = 1'b0;
                tick_d[i] = 1'b0;
                if (pend_q[i]) begin
                    half_d[i] = pval_q[i];
                end
                if (hit[i]) begin
                    pval_d[i] = load_val;
                    pend_d[i] = 1'b1;
                end else begin
                    pend_d[i] = 1'b0;
                end
            end else if (!en[i]) begin
                cnt_d[i]  = '0;
                clk_d[i]  = 1'b0;
                tick_d[i] = 1'b0;
                if (hit[i]) begin
                    half_d[i] = load_val;
                    pval_d[i] = load_val;
                    pend_d[i] = 1'b0;
                end else if (pend_q[i]) begin
                    half_d[i] = pval_q[i];
                    pend_d[i] = 1'b0;
                end
            end else if (cnt_q[i] == half_q[i]) begin
                // half only changes here, while cnt returns to 0, so cnt <= half always.
                cnt_d[i]  = '0;
                clk_d[i]  = ~clk_q[i];
                tick_d[i] = 1'b1;
                if (pend_q[i]) begin
                    half_d[i] = pval_q[i];
                end
                if (hit[i]) begin
                    pval_d[i] = load_val;
                    pend_d[i] = 1'b1;
                end else begin
                    pend_d[i] = 1'b0;
                end
            end else begin
                cnt_d[i]  = cnt_q[i] + CW'(1);
                tick_d[i] = 1'b0;
                if (hit[i]) begin
                    pval_d[i] = load_val;
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= '0;
                half_q[i] <= DEF_HALF_C;
                pval_q[i] <= DEF_HALF_C;
            end
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                half_q[i] <= half_d[i];
                pval_q[i] <= pval_d[i];
            end
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter CW, default 24: width of each channel's counter and half-period value.
REQ-003 Parameter DEF_HALF, default 200000: half-period value loaded into every channel at reset; must fit in CW bits.
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; reset=0 clears the block immediately, independent of clk.
REQ-006 en  in  NCH  per-channel enable, sampled on the clk edge.
REQ-007 load  in  1  one-cycle write strobe for a new half-period value.
REQ-008 load_ch  in  clog2(NCH), minimum 1  target channel index for load.
REQ-009 load_val  in  CW  new half-period value.
REQ-010 sync  in  1  one-cycle strobe that restarts all channels in phase.
REQ-011 clk_out  out  NCH  divided clock per channel, registered.
REQ-012 tick  out  NCH  one-cycle pulse per channel, high in the cycle clk_out toggles, registered.

Function
REQ-013 Each channel holds four registers: counter cnt, active half-period half, shadow value pval, and pending flag pend.
REQ-014 Enabled channel, normal edge: if cnt != half, cnt<=cnt+1 and tick<=0.
REQ-015 Enabled channel, terminal edge (cnt == half): cnt<=0, clk_out toggles, tick<=1.
- Toggle interval is half+1 cycles; clk_out period is 2*(half+1) cycles.
- DEF_HALF=200000 gives a toggle every 200001 cycles.
REQ-016 half=0: clk_out toggles every cycle (period 2) and tick stays high continuously.
REQ-017 load with load_ch < NCH: pval[load_ch]<=load_val and pend<=1; a later load before the value is applied overwrites it (last write wins).
REQ-018 load with load_ch >= NCH is ignored; no state changes.
REQ-019 A pending value is applied on the channel's next terminal edge: half<=pval and pend<=0, in the same edge as the toggle, so the current half-period is never truncated or extended.
REQ-020 Disabled channel (en=0): cnt<=0, clk_out<=0, tick<=0 each edge; any pending value is applied immediately.
- A load to a disabled channel takes effect on that same edge.
REQ-021 Re-enable: first toggle occurs half+1 edges after the first edge sampled with en=1.
REQ-022 sync edge, all channels: cnt<=0, clk_out<=0, tick<=0, and any previously pending values are applied.
- sync overrides a terminal edge in the same cycle.
- A load in the same cycle as sync becomes pending only; it is applied on the next terminal edge.
REQ-023 cnt never exceeds half: half only changes when cnt is being set to 0, so no wrap-around occurs.
REQ-024 Channels are fully independent apart from sync; there is no combinational path from any input to any output.

Reset
REQ-025 While reset=0, every channel: cnt=0, half=DEF_HALF, pval=DEF_HALF, pend=0, clk_out=0, tick=0.
REQ-026 Asserting reset mid-count or with a load pending discards all state asynchronously; no tick is produced.
REQ-027 On the first edge after reset returns to 1, normal operation per REQ-014..REQ-022 starts, with cnt counting from 0.

Verification
REQ-028 Defaults, en=4'b0001:
- clk_out[0] rises on the 200001st edge after reset release, with tick[0] high for 1 cycle.
- clk_out[0] falls 200001 edges later; verify 3 consecutive toggles.
- clk_out[3:1] and tick[3:1] stay 0 throughout.
REQ-029 ch1 running at DEF_HALF; load ch1=3 at cnt=100:
- the current half-period still completes at 200001 cycles;
- afterwards clk_out[1] has period 8 (toggle every 4 edges).
REQ-030 load ch2=0 with en[2]=0, then set en[2]=1:
- clk_out[2] toggles every edge;
- tick[2] is continuously 1.
REQ-031 ch0 and ch1 with half=9 and unequal phase; pulse sync:
- next edge: both clk_out=0;
- both then toggle together every 10 edges.
REQ-032 load ch3=5 in the same cycle as sync: ch3 keeps its old half for the first post-sync interval, then switches to 6-edge toggles.
REQ-033 Two further cases:
- load_ch=NCH (out of range): no state change.
- reset=0 mid-operation: all outputs 0 within the same cycle, and half=DEF_HALF after release.
